uarts_rx_fifo_ctl: RTL

// - Self-timed UART receiver: start-bit detection, mid-bit sampling, optional parity check.
// - Packs 1/2/4 received bytes into one word and buffers the words in a receive FIFO.
// - Reports sticky parity/framing/overrun errors and raises a threshold/error interrupt.
// - Sits between the RX pad and the UART register block; needs no external bit strobe.

---
 rtl/uarts_rx_fifo_ctl_pkg.sv | 42 ++++
 rtl/uarts_rx_fifo_ctl_if.sv | 31 +++
 rtl/uarts_rx_fifo_ctl_sync_fifo.sv | 63 ++++++
 rtl/uarts_rx_fifo_ctl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uarts_rx_fifo_ctl_pkg.sv
// rtl/uarts_rx_fifo_ctl_pkg.sv - shared encodings for the UART receive path
// Holds the receiver FSM state encodings, the uarts_ctl field positions,
// the byte-packing width-mode codes and small helpers used by the receiver.
package uarts_rx_fifo_ctl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BRK    = 3'd5
   } rx_state_t;

   // uarts_ctl field positions
   localparam int CTL_MODE_LSB = 0;   // [1:0] packing mode
   localparam int CTL_PAR_EN   = 2;   // parity enable
   localparam int CTL_PAR_EVEN = 3;   // 1 = even, 0 = odd

   // packing mode codes
   localparam logic [1:0] MODE_1B     = 2'b00;
   localparam logic [1:0] MODE_2B     = 2'b01;
   localparam logic [1:0] MODE_4B     = 2'b10;
   localparam logic [1:0] MODE_1B_ALT = 2'b11;

   // index of the byte that completes a word in the given mode
   function automatic logic [1:0] last_byte_idx(input logic [1:0] mode);
      case (mode)
         MODE_1B, MODE_1B_ALT: return 2'd0;
         MODE_2B:              return 2'd1;
         MODE_4B:              return 2'd3;
         default:              return 2'd0;
      endcase
   endfunction

   // even parity: data plus parity bit carry an even number of ones
   function automatic logic parity_ok(input logic [7:0] d, input logic pbit,
                                      input logic even);
      return even ? ~(^{d, pbit}) : (^{d, pbit});
   endfunction

endpackage

// File: rtl/uarts_rx_fifo_ctl_if.sv
// rtl/uarts_rx_fifo_ctl_if.sv - host-side read/status bundle of the UART receiver
// Ports carried:
//   rx_rd, err_clr                      host -> receiver (pop, clear sticky errors)
//   rx_data, rx_valid, rx_level         FIFO head / not-empty / occupancy
//   parity_err, frame_err, overrun_err  sticky error flags
//   rx_irq                              registered interrupt
// Modports: master = register block side, slave = receiver side.
interface uarts_rx_fifo_ctl_if #(
   parameter int DATA_W = 32,
   parameter int LVL_W  = 4
) ();
   logic              rx_rd;
   logic              err_clr;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic [LVL_W-1:0]  rx_level;
   logic              parity_err;
   logic              frame_err;
   logic              overrun_err;
   logic              rx_irq;

   modport master (
      output rx_rd, err_clr,
      input  rx_data, rx_valid, rx_level, parity_err, frame_err, overrun_err, rx_irq
   );

   modport slave (
      input  rx_rd, err_clr,
      output rx_data, rx_valid, rx_level, parity_err, frame_err, overrun_err, rx_irq
   );
endinterface

// File: rtl/uarts_rx_fifo_ctl_sync_fifo.sv
// rtl/uarts_rx_fifo_ctl_sync_fifo.sv - first-word-fall-through word FIFO for the UART receiver
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   push, push_data write request and word
//   pop             pop request (ignored while empty)
//   pop_data        head word, 0 while empty
//   empty, level    status; level saturates at DEPTH
//   drop            push refused because full with no simultaneous pop
module uarts_rx_fifo_ctl_sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic                     hclk,
   input  logic                     hresetn,
   input  logic                     push,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [DATA_W-1:0]        pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       cnt;
   logic              full, do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == CNT_FULL);
   assign do_pop  = pop & ~empty;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign do_push = push & (~full | do_pop);
   assign drop    = push & ~do_push;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         if (do_push && !do_pop)
            cnt <= cnt + CNT_ONE;
         else if (do_pop && !do_push)
            cnt <= cnt - CNT_ONE;
      end
   end

   always_ff @(posedge hclk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = empty ? '0 : mem[rd_ptr];
   assign level    = cnt;

endmodule

// File: rtl/uarts_rx_fifo_ctl.sv
// rtl/uarts_rx_fifo_ctl.sv - self-timed UART receiver with word packing and receive FIFO
// Receives 8-bit frames on RX, packs 1/2/4 bytes per word (uarts_ctl[1:0]),
// buffers words in a FIFO and reports sticky parity/framing/overrun errors.
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   uarts_baud      hclk cycles per bit (>=4)
//   uarts_ctl       [1:0] packing mode, [2] parity enable, [3] even parity
//   rx_thresh       FIFO level interrupt threshold, 0 disables the level term
//   RX              asynchronous serial input, idle high
//   host            read/status bundle (uarts_rx_fifo_ctl_if.slave)
// Build option: define UARTS_RX_PARITY_EN to build the parity state and honour
// uarts_ctl[3:2]; otherwise frames are always 8N1 and parity_err is 0.
module uarts_rx_fifo_ctl
   import uarts_rx_fifo_ctl_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 8,
   parameter int SYNC_STG   = 2
) (
   input  logic                            hclk,
   input  logic                            hresetn,
   input  logic [15:0]                     uarts_baud,
   input  logic [3:0]                      uarts_ctl,
   input  logic [$clog2(FIFO_DEPTH):0]     rx_thresh,
   input  logic                            RX,
   uarts_rx_fifo_ctl_if.slave              host
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   // ---------------- RX synchroniser and edge detect ----------------
   logic [SYNC_STG-1:0] rx_sync;
   logic                rx_s, rx_prev, rx_fall;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         rx_sync <= '1;
         rx_prev <= 1'b1;
      end else begin
         rx_sync <= {rx_sync[SYNC_STG-2:0], RX};
         rx_prev <= rx_s;
      end
   end

   assign rx_s    = rx_sync[SYNC_STG-1];
   assign rx_fall = rx_prev & ~rx_s;

   // ---------------- receiver FSM ----------------
   rx_state_t         state, state_nx;
   logic [15:0]       cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        shreg;
   logic [1:0]        byte_idx;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] word_q, word_merged, push_word;
   logic              push_req;
   logic              tick;
   logic              ld_half, ld_full, shift_en, byte_ok, frame_ev, latch_ctl;
   logic              frame_err_q, overrun_err_q, irq_q;
   logic              fifo_empty, fifo_drop;
   logic [LVL_W-1:0]  fifo_level;

`ifdef UARTS_RX_PARITY_EN
   logic par_en_q, par_even_q, par_ev, parity_err_q;
`else
   logic ctl_unused;
   assign ctl_unused = ^uarts_ctl[CTL_PAR_EVEN:CTL_PAR_EN];
`endif

   assign tick = (cnt == 16'd0);

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) state <= ST_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ld_half   = 1'b0;
      ld_full   = 1'b0;
      shift_en  = 1'b0;
      byte_ok   = 1'b0;
      frame_ev  = 1'b0;
      latch_ctl = 1'b0;
`ifdef UARTS_RX_PARITY_EN
      par_ev    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (rx_fall) begin
               state_nx  = ST_START;
               ld_half   = 1'b1;
               // the control word only changes on word boundaries
               latch_ctl = (byte_idx == 2'd0);
            end
         end
         ST_START: begin
            if (tick) begin
               if (rx_s) begin
                  state_nx = ST_IDLE;   // glitch, not a real start bit
               end else begin
                  state_nx = ST_DATA;
                  ld_full  = 1'b1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               ld_full  = 1'b1;
               if (bit_idx == 3'd7) begin
`ifdef UARTS_RX_PARITY_EN
                  state_nx = par_en_q ? ST_PARITY : ST_STOP;
`else
                  state_nx = ST_STOP;
`endif
               end
            end
         end
`ifdef UARTS_RX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               ld_full  = 1'b1;
               par_ev   = ~parity_ok(shreg, rx_s, par_even_q);
               state_nx = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (rx_s) begin
                  byte_ok  = 1'b1;
                  state_nx = ST_IDLE;
               end else begin
                  frame_ev = 1'b1;
                  state_nx = ST_BRK;
               end
            end
         end
         ST_BRK: begin
            if (rx_s) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // merge the just-received byte into its lane of the partial word
   always_comb begin
      word_merged = word_q;
      word_merged[{byte_idx, 3'b000} +: 8] = shreg;
   end

   // ---------------- bit timing, shifting and packing ----------------
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         cnt       <= 16'd0;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
         byte_idx  <= 2'd0;
         mode_q    <= MODE_1B;
         word_q    <= '0;
         push_req  <= 1'b0;
         push_word <= '0;
`ifdef UARTS_RX_PARITY_EN
         par_en_q   <= 1'b0;
         par_even_q <= 1'b0;
`endif
      end else begin
         push_req <= 1'b0;

         // half a bit to reach mid start bit, then whole bits
         if (ld_half)
            cnt <= uarts_baud >> 1;
         else if (ld_full)
            cnt <= uarts_baud - 16'd1;
         else if (!tick)
            cnt <= cnt - 16'd1;

         if (latch_ctl) begin
            mode_q <= uarts_ctl[CTL_MODE_LSB +: 2];
`ifdef UARTS_RX_PARITY_EN
            par_en_q   <= uarts_ctl[CTL_PAR_EN];
            par_even_q <= uarts_ctl[CTL_PAR_EVEN];
`endif
         end

         if (ld_half) bit_idx <= 3'd0;

         if (shift_en) begin
            shreg   <= {rx_s, shreg[7:1]};   // LSB arrives first
            bit_idx <= bit_idx + 3'd1;
         end

         if (byte_ok) begin
            if (byte_idx == last_byte_idx(mode_q)) begin
               push_req  <= 1'b1;
               push_word <= word_merged;
               word_q    <= '0;
               byte_idx  <= 2'd0;
            end else begin
               word_q   <= word_merged;
               byte_idx <= byte_idx + 2'd1;
            end
         end

         // a framing error throws away the partial word too
         if (frame_ev) begin
            word_q   <= '0;
            byte_idx <= 2'd0;
         end
      end
   end

   // ---------------- receive FIFO ----------------
   uarts_rx_fifo_ctl_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .push      (push_req),
      .push_data (push_word),
      .pop       (host.rx_rd),
      .pop_data  (host.rx_data),
      .empty     (fifo_empty),
      .level     (fifo_level),
      .drop      (fifo_drop)
   );

   // ---------------- sticky errors and interrupt ----------------
   // a new error event outranks err_clr in the same cycle
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         irq_q         <= 1'b0;
`ifdef UARTS_RX_PARITY_EN
         parity_err_q  <= 1'b0;
`endif
      end else begin
         if (frame_ev)          frame_err_q <= 1'b1;
         else if (host.err_clr) frame_err_q <= 1'b0;

         if (fifo_drop)         overrun_err_q <= 1'b1;
         else if (host.err_clr) overrun_err_q <= 1'b0;

`ifdef UARTS_RX_PARITY_EN
         if (par_ev)            parity_err_q <= 1'b1;
         else if (host.err_clr) parity_err_q <= 1'b0;

         irq_q <= ((rx_thresh != '0) && (fifo_level >= rx_thresh))
                  | frame_err_q | overrun_err_q | parity_err_q;
`else
         irq_q <= ((rx_thresh != '0) && (fifo_level >= rx_thresh))
                  | frame_err_q | overrun_err_q;
`endif
      end
   end

   assign host.rx_valid    = ~fifo_empty;
   assign host.rx_level    = fifo_level;
   assign host.frame_err   = frame_err_q;
   assign host.overrun_err = overrun_err_q;
   assign host.rx_irq      = irq_q;
`ifdef UARTS_RX_PARITY_EN
   assign host.parity_err  = parity_err_q;
`else
   assign host.parity_err  = 1'b0;
`endif

endmodule
